// File: rtl/multicycle_controller.sv
// Multi-cycle control unit for the 16-bit register-window datapath.
// Classifies the instruction once in DECODE and drives selects/enables from that class until FETCH.
module multicycle_controller #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [7:0]       funcType,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             irwr,
  output logic             pcwr,
  output logic             selimm,
  output logic             selALU,
  output logic             selmem,
  output logic             selbr,
  output logic             seljump,
  output logic             wEn,
  output logic             memwEn,
  output logic             ldwnd,
  output logic [2:0]       func,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEMRD, S_MEMWR, S_WB, S_HALT} state_t;
  typedef enum logic [3:0] {C_ALU, C_IMM, C_MOVE, C_JUMP, C_BRZ, C_WND, C_NOP, C_ILL,
                            C_LOAD, C_STORE, C_HALT} cls_t;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t        state, state_n;
  cls_t          cls_q, cls_d;
  logic [2:0]    op_q, op_d;
  logic [TW-1:0] wcnt;
  logic          ill_set, timeout, act;

  // Instruction classification; only consumed in DECODE.
  always_comb begin
    cls_d = C_ILL;
    op_d  = 3'b000;
    case (opcode)
      4'h0: cls_d = C_LOAD;
      4'h1: cls_d = C_STORE;
      4'h2: cls_d = C_JUMP;
      4'h3: cls_d = C_HALT;
      4'h4: begin cls_d = C_BRZ; op_d = 3'b010; end
      4'h9: cls_d = C_WND;
      4'hC, 4'hD, 4'hE, 4'hF: begin
        cls_d = C_IMM;
        op_d  = {1'b0, opcode[1:0]} + 3'd1;
      end
      4'h8: begin
        case (funcType)
          8'h01, 8'h02: cls_d = C_MOVE;
          8'h04: begin cls_d = C_ALU; op_d = 3'b001; end
          8'h08: begin cls_d = C_ALU; op_d = 3'b010; end
          8'h10: begin cls_d = C_ALU; op_d = 3'b011; end
          8'h20: begin cls_d = C_ALU; op_d = 3'b100; end
          8'h40: begin cls_d = C_ALU; op_d = 3'b101; end
          8'h80: cls_d = C_NOP;
          default: cls_d = C_ILL;
        endcase
      end
      default: cls_d = C_ILL;
    endcase
  end

  assign timeout = (wcnt == TW'(MEM_TIMEOUT - 1)) && !mem_ready;
  assign act     = (state == S_EXEC) || (state == S_MEMRD) || (state == S_MEMWR) || (state == S_WB);

  always_comb begin
    state_n = state;
    irwr    = 1'b0;
    pcwr    = 1'b0;
    wEn     = 1'b0;
    memwEn  = 1'b0;
    halted  = 1'b0;
    ill_set = 1'b0;
    func    = 3'b000;
    selimm  = 1'b0;
    selALU  = 1'b0;
    selmem  = 1'b0;
    selbr   = 1'b0;
    seljump = 1'b0;
    ldwnd   = 1'b0;
    // Selects come from the latched class so they hold from EXEC through WB.
    if (act) begin
      func    = op_q;
      selimm  = (cls_q == C_IMM);
      selALU  = (cls_q == C_IMM) || (cls_q == C_ALU);
      selmem  = (cls_q == C_LOAD);
      seljump = (cls_q == C_JUMP);
      selbr   = (cls_q == C_BRZ) && zero;
      ldwnd   = (cls_q == C_WND);
    end
    case (state)
      S_FETCH: begin
        irwr    = rst;  // reset state is FETCH, but no IR load while held in reset
        state_n = S_DECODE;
      end
      S_DECODE: begin
        case (cls_d)
          C_LOAD:  state_n = S_MEMRD;
          C_STORE: state_n = S_MEMWR;
          C_HALT:  state_n = S_HALT;
          default: state_n = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if ((cls_q == C_IMM) || (cls_q == C_ALU) || (cls_q == C_MOVE)) begin
          state_n = S_WB;
        end else begin
          pcwr    = 1'b1;
          ill_set = (cls_q == C_ILL);
          state_n = S_FETCH;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          state_n = S_WB;
        end else if (timeout) begin
          pcwr    = 1'b1;
          ill_set = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_MEMWR: begin
        memwEn = 1'b1;
        if (mem_ready || timeout) begin
          pcwr    = 1'b1;
          ill_set = timeout;
          state_n = S_FETCH;
        end
      end
      S_WB: begin
        wEn     = 1'b1;
        pcwr    = 1'b1;
        state_n = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      cls_q   <= C_NOP;
      op_q    <= 3'b000;
      wcnt    <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) begin
        cls_q <= cls_d;
        op_q  <= op_d;
        wcnt  <= '0;
      end else if ((state == S_MEMRD) || (state == S_MEMWR)) begin
        wcnt <= wcnt + 1'b1;
      end
      if (ill_set) illegal <= 1'b1;
      if (pcwr)    retired <= retired + 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level model expands each
// instruction into its expected per-cycle outputs, which one compare process checks.
module tb_multicycle_controller;
  localparam int MEM_TO = 255;

  typedef struct packed {
    logic        irwr, pcwr, selimm, selALU, selmem, selbr, seljump, wEn, memwEn, ldwnd;
    logic [2:0]  func;
    logic        halted, illegal;
    logic [15:0] retired;
  } obs_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic [3:0]  opcode = '0;
  logic [7:0]  funcType = '0;
  logic        zero = 1'b0, mem_ready = 1'b0;
  logic        irwr, pcwr, selimm, selALU, selmem, selbr, seljump, wEn, memwEn, ldwnd;
  logic [2:0]  func;
  logic        halted, illegal;
  logic [15:0] retired;

  multicycle_controller #(.CNT_W(16), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funcType(funcType), .zero(zero),
    .mem_ready(mem_ready), .irwr(irwr), .pcwr(pcwr), .selimm(selimm), .selALU(selALU),
    .selmem(selmem), .selbr(selbr), .seljump(seljump), .wEn(wEn), .memwEn(memwEn),
    .ldwnd(ldwnd), .func(func), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  obs_t dut_obs;
  assign dut_obs = {irwr, pcwr, selimm, selALU, selmem, selbr, seljump, wEn, memwEn, ldwnd,
                    func, halted, illegal, retired};

  obs_t        q[$];
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  logic [15:0] m_ret = '0;
  logic        m_ill = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (q.size() > 0) begin
      obs_t e;
      e = q.pop_front();
      n_cmp++;
      if (dut_obs !== e) begin
        n_bad++;
        $display("FAIL cycle%0d outputs: got %h want %h", cyc, dut_obs, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One cycle: expectation for the current cycle, then advance the model.
  task automatic step(input obs_t e, input logic rdy, input logic set_ill);
    e.illegal = m_ill;
    e.retired = m_ret;
    mem_ready = rdy;
    q.push_back(e);
    @(posedge clk); #1;
    if (e.pcwr) m_ret++;
    if (set_ill) m_ill = 1'b1;
  endtask

  // waits = cycles with mem_ready low before it rises (>= MEM_TO means never); HALT: cycles to observe.
  task automatic instr(input logic [3:0] op, input logic [7:0] ft, input logic z, input int waits);
    obs_t e;
    int   idx;
    bit   onehot;
    opcode = op; funcType = ft; zero = z;
    e = '0; e.irwr = 1'b1; step(e, 1'b0, 1'b0);
    e = '0; step(e, 1'b0, 1'b0);
    opcode = ~op; funcType = ~ft;  // must be ignored after DECODE
    e = '0;
    onehot = ($countones(ft) == 1);
    idx = 0;
    for (int i = 0; i < 8; i++) if (ft[i]) idx = i;
    case (op)
      4'h0, 4'h1: begin
        if (op == 4'h0) e.selmem = 1'b1; else e.memwEn = 1'b1;
        if (waits >= MEM_TO) begin
          repeat (MEM_TO - 1) step(e, 1'b0, 1'b0);
          e.pcwr = 1'b1; step(e, 1'b0, 1'b1);
        end else begin
          repeat (waits) step(e, 1'b0, 1'b0);
          if (op == 4'h0) begin
            step(e, 1'b1, 1'b0);
            e.wEn = 1'b1; e.pcwr = 1'b1; step(e, 1'b0, 1'b0);
          end else begin
            e.pcwr = 1'b1; step(e, 1'b1, 1'b0);
          end
        end
      end
      4'h2: begin e.seljump = 1'b1; e.pcwr = 1'b1; step(e, 1'b0, 1'b0); end
      4'h3: begin e.halted = 1'b1; repeat (waits) step(e, 1'b0, 1'b0); end
      4'h4: begin e.func = 3'b010; e.selbr = z; e.pcwr = 1'b1; step(e, 1'b0, 1'b0); end
      4'h9: begin e.ldwnd = 1'b1; e.pcwr = 1'b1; step(e, 1'b0, 1'b0); end
      4'hC, 4'hD, 4'hE, 4'hF: begin
        e.func = 3'(op[1:0]) + 3'd1; e.selimm = 1'b1; e.selALU = 1'b1;
        step(e, 1'b0, 1'b0);
        e.wEn = 1'b1; e.pcwr = 1'b1; step(e, 1'b0, 1'b0);
      end
      4'h8: begin
        if (!onehot) begin
          e.pcwr = 1'b1; step(e, 1'b0, 1'b1);
        end else if (idx == 7) begin
          e.pcwr = 1'b1; step(e, 1'b0, 1'b0);
        end else begin
          if (idx >= 2) begin e.func = 3'(idx - 1); e.selALU = 1'b1; end
          step(e, 1'b0, 1'b0);
          e.wEn = 1'b1; e.pcwr = 1'b1; step(e, 1'b0, 1'b0);
        end
      end
      default: begin e.pcwr = 1'b1; step(e, 1'b0, 1'b1); end
    endcase
  endtask

  initial begin
    obs_t e;
    #2;
    chk("reset_irwr", 32'(irwr), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    chk("reset_halted_illegal", {30'd0, halted, illegal}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    instr(4'hC, 8'h00, 1'b0, 0);          // ADDI
    chk("addi_retired", 32'(retired), 32'd1);
    instr(4'h0, 8'h00, 1'b0, 3);          // LOAD, 3 wait cycles
    instr(4'h4, 8'h00, 1'b1, 0);          // BRZ taken
    instr(4'h4, 8'h00, 1'b0, 0);          // BRZ not taken
    instr(4'h8, 8'h04, 1'b0, 0);          // ADD
    instr(4'h8, 8'h01, 1'b0, 0);          // MOVETO
    instr(4'h8, 8'h40, 1'b0, 0);          // NOT
    instr(4'h8, 8'h80, 1'b0, 0);          // NOP
    instr(4'h2, 8'h00, 1'b0, 0);          // JUMP
    instr(4'h9, 8'h00, 1'b0, 0);          // WND
    instr(4'hD, 8'h00, 1'b0, 0);          // SUBI
    instr(4'hF, 8'h00, 1'b0, 0);          // ORI
    instr(4'h1, 8'h00, 1'b0, 2);          // STORE, 2 waits
    chk("pre_timeout_illegal", 32'(illegal), 32'd0);
    instr(4'h1, 8'h00, 1'b0, MEM_TO);     // STORE timeout
    chk("timeout_illegal", 32'(illegal), 32'd1);
    chk("timeout_retired", 32'(retired), 32'd14);

    // Reset while a store is in progress
    opcode = 4'h1;
    e = '0; e.irwr = 1'b1; step(e, 1'b0, 1'b0);
    e = '0; step(e, 1'b0, 1'b0);
    e = '0; e.memwEn = 1'b1;
    repeat (3) step(e, 1'b0, 1'b0);
    chk("mid_memwr_memwEn", 32'(memwEn), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_memwEn", 32'(memwEn), 32'd0);
    chk("async_rst_irwr", 32'(irwr), 32'd0);
    chk("async_rst_retired", 32'(retired), 32'd0);
    chk("async_rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    m_ret = '0; m_ill = 1'b0;

    instr(4'hC, 8'h00, 1'b0, 0);          // ADDI after reset
    instr(4'h8, 8'h06, 1'b0, 0);          // multi-hot RTYPE: illegal
    chk("multihot_illegal", 32'(illegal), 32'd1);
    chk("multihot_retired", 32'(retired), 32'd2);
    instr(4'h3, 8'h00, 1'b0, 10);         // HALT
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_irwr", 32'(irwr), 32'd0);
    chk("halt_retired", 32'(retired), 32'd2);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
